// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, opcodes,
// FSM state type and the per-load tracking record.
package rv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0]  OPCODE_LOAD       = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE      = 7'b0100011;
    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ERR
    } lsu_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_meta_t;

    localparam int META_W = $bits(lsu_meta_t);

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// EX-side request/response channel and the data-memory req/gnt/rvalid bus.
interface rv32_lsu_ex_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err);
endinterface

interface rv32_lsu_if;
    logic        dmem_req;
    logic        dmem_gnt;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic        dmem_ren;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (output dmem_req, dmem_addr, dmem_wen, dmem_ren, dmem_wdata, dmem_wmask,
                    input  dmem_gnt, dmem_rvalid, dmem_rdata);
    modport slave  (input  dmem_req, dmem_addr, dmem_wen, dmem_ren, dmem_wdata, dmem_wmask,
                    output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/rv32_lsu_meta_fifo.sv
// In-order tracking FIFO for granted loads; pointers carry an extra wrap bit
// so full and empty are distinguished without a counter.
module lsu_meta_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]      wptr_q, rptr_q;

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
        return p + (AW+1)'(1);
    endfunction

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: EX request -> req/gnt/rvalid data bus, with lane steering,
// load extension, misalignment trapping and a response timeout on the oldest load.
module rv32_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          TIMEOUT_CYCLES  = 256,
    parameter logic [31:0] IDLE_ADDR       = IDLE_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    rv32_lsu_ex_if.slave    ex,
    rv32_lsu_if.master      dmem,
    output logic            misaligned,
    output logic            timeout,
    output logic            spurious
);
    localparam int             TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    state_q;
    lsu_meta_t     meta_q, head;
    logic [TW-1:0] timer_q;
    logic          dmem_req_q, dmem_wen_q, dmem_ren_q;
    logic [31:0]   dmem_addr_q, dmem_wdata_q;
    logic [3:0]    dmem_wmask_q;
    logic          rsp_valid_q, rsp_err_q, misaligned_q, timeout_q, spurious_q;
    logic [4:0]    rsp_rd_q;
    logic [31:0]   rsp_data_q;
    logic          req_mis, req_ready_d, accept;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, rv_hit, to_hit;

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_BU:   return {24'b0, sh[7:0]};
            F3_HU:   return {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // A misaligned op is only taken with no loads in flight, so its error
    // response can never collide with a load response.
    always_comb begin
        req_mis     = is_misaligned(ex.req_funct3, ex.req_addr[1:0]);
        req_ready_d = (state_q == ST_IDLE) && !(!ex.req_we && fifo_full)
                      && !(req_mis && !fifo_empty);
        accept      = ex.req_valid && req_ready_d;
        fifo_push   = (state_q == ST_REQ) && dmem.dmem_gnt && dmem_ren_q;
        rv_hit      = dmem.dmem_rvalid && !fifo_empty;
        to_hit      = !fifo_empty && !dmem.dmem_rvalid && (timer_q == TIMER_LAST);
        fifo_pop    = rv_hit || to_hit;
    end

    lsu_meta_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (META_W)
    ) u_meta_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (meta_q),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            meta_q       <= '0;
            timer_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_ren_q   <= 1'b0;
            dmem_addr_q  <= IDLE_ADDR;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rd_q     <= '0;
            rsp_data_q   <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            spurious_q   <= dmem.dmem_rvalid && fifo_empty;
            timer_q      <= (fifo_pop || fifo_empty) ? '0 : timer_q + 1'b1;

            if (rv_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_rd_q    <= head.rd;
                rsp_data_q  <= load_extend(head.funct3, head.off, dmem.dmem_rdata);
            end else if (to_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                timeout_q   <= 1'b1;
                rsp_rd_q    <= head.rd;
                rsp_data_q  <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept && req_mis) begin
                        state_q      <= ST_ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b1;
                        misaligned_q <= 1'b1;
                        rsp_rd_q     <= ex.req_we ? 5'd0 : ex.req_rd;
                        rsp_data_q   <= '0;
                    end else if (accept) begin
                        state_q      <= ST_REQ;
                        dmem_req_q   <= 1'b1;
                        dmem_addr_q  <= {ex.req_addr[31:2], 2'b00};
                        dmem_wen_q   <= ex.req_we;
                        dmem_ren_q   <= !ex.req_we;
                        dmem_wdata_q <= ex.req_we ? store_data(ex.req_funct3, ex.req_wdata) : '0;
                        dmem_wmask_q <= ex.req_we ? store_mask(ex.req_funct3, ex.req_addr[1:0]) : '0;
                        meta_q       <= '{rd: ex.req_rd, funct3: ex.req_funct3,
                                          off: ex.req_addr[1:0]};
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_gnt) begin
                        state_q      <= ST_IDLE;
                        dmem_req_q   <= 1'b0;
                        dmem_wen_q   <= 1'b0;
                        dmem_ren_q   <= 1'b0;
                        dmem_addr_q  <= IDLE_ADDR;
                        dmem_wdata_q <= '0;
                        dmem_wmask_q <= '0;
                    end
                end
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ex.req_ready      = req_ready_d;
    assign ex.rsp_valid      = rsp_valid_q;
    assign ex.rsp_rd         = rsp_rd_q;
    assign ex.rsp_data       = rsp_data_q;
    assign ex.rsp_err        = rsp_err_q;
    assign dmem.dmem_req     = dmem_req_q;
    assign dmem.dmem_addr    = dmem_addr_q;
    assign dmem.dmem_wen     = dmem_wen_q;
    assign dmem.dmem_ren     = dmem_ren_q;
    assign dmem.dmem_wdata   = dmem_wdata_q;
    assign dmem.dmem_wmask   = dmem_wmask_q;
    assign misaligned        = misaligned_q;
    assign timeout           = timeout_q;
    assign spurious          = spurious_q;

endmodule
